rr_arbiter8: RTL and testbench



---
 rtl/rr_arbiter8.sv | 167 ++++++++++++++++
 tb/tb_rr_arbiter8.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter8.sv
// rr_arbiter8: eight-requester round-robin arbiter for a shared one-hot select.
// The winner's index drives the 3-to-8 decode select (grant_idx_out) and the
// registered decoded form (grant_out). The grant is held until the holder
// drops its request or pulses done_in.
// Optional hold timeout: define RR_ARB_TIMEOUT_EN to build the hold counter
// that forces a release after HOLD_MAX visible grant cycles. When the macro is
// undefined, timeout_out is tied low and HOLD_MAX is unused.
module rr_arbiter8 #(
    parameter int unsigned HOLD_MAX = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req_in,
    input  logic       done_in,
    output logic [7:0] grant_out,
    output logic [2:0] grant_idx_out,
    output logic       grant_valid_out,
    output logic       timeout_out
);

    // Reject out-of-range hold limits at elaboration.
    if ((HOLD_MAX < 2) || (HOLD_MAX > 255)) begin : g_hold_max_check
        $error("rr_arbiter8: HOLD_MAX must be within 2..255");
    end

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [2:0] r_ptr;
    logic [2:0] w_ptr_nxt;
    logic [7:0] r_grant;
    logic [7:0] w_grant_nxt;
    logic [2:0] r_idx;
    logic [2:0] w_idx_nxt;
    logic       r_valid;
    logic       w_valid_nxt;

    logic       w_rel_a;
    logic       w_rel_b;
    logic       w_rel_c;
    logic       w_release;

    // First requester found when scanning ptr, ptr+1, ... ptr+7 (mod 8).
    function automatic logic [2:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr);
        logic [2:0] idx;
        logic       found;
        rr_pick = ptr;
        found   = 1'b0;
        for (int k = 0; k < 8; k++) begin
            idx = ptr + 3'(k);
            if (!found && req[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    // Binary index to one-hot select.
    function automatic logic [7:0] onehot8(input logic [2:0] idx);
        onehot8 = 8'h01 << idx;
    endfunction

    assign w_rel_a   = ~req_in[r_idx];
    assign w_rel_b   = done_in;
    assign w_release = w_rel_a | w_rel_b | w_rel_c;

`ifdef RR_ARB_TIMEOUT_EN
    logic [7:0] r_cnt;
    logic       r_timeout;
    logic       w_timeout_nxt;

    // Counter sits at zero in IDLE, so it reads 0 in the first grant cycle;
    // it therefore reads HOLD_MAX-1 in the last cycle the grant may be shown.
    assign w_rel_c = (r_cnt == 8'(HOLD_MAX - 1));

    // Timeout is flagged only when it is the sole cause of the release.
    assign w_timeout_nxt = (r_state == ST_GRANT) & w_rel_c & ~w_rel_a & ~w_rel_b;

    // Hold counter: cleared while idle, counts every cycle in GRANT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= 8'd0;
        end else if (r_state == ST_IDLE) begin
            r_cnt <= 8'd0;
        end else begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    // Timeout pulse register: high for the first IDLE cycle after a forced release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_timeout_nxt;
        end
    end

    assign timeout_out = r_timeout;
`else
    assign w_rel_c     = 1'b0;
    assign timeout_out = 1'b0;
`endif

    // Next-state and next-output logic for the IDLE/GRANT machine.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_grant_nxt = r_grant;
        w_idx_nxt   = r_idx;
        w_valid_nxt = r_valid;
        case (r_state)
            ST_IDLE: begin
                if (req_in != 8'h00) begin
                    w_idx_nxt   = rr_pick(req_in, r_ptr);
                    w_grant_nxt = onehot8(w_idx_nxt);
                    w_valid_nxt = 1'b1;
                    w_state_nxt = ST_GRANT;
                end else begin
                    w_grant_nxt = 8'h00;
                    w_valid_nxt = 1'b0;
                end
            end
            ST_GRANT: begin
                if (w_release) begin
                    w_state_nxt = ST_IDLE;
                    w_grant_nxt = 8'h00;
                    w_valid_nxt = 1'b0;
                    w_ptr_nxt   = r_idx + 3'd1;
                end else begin
                    w_state_nxt = ST_GRANT;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = 8'h00;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    // State, pointer and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_ptr   <= 3'd0;
            r_grant <= 8'h00;
            r_idx   <= 3'd0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_grant <= w_grant_nxt;
            r_idx   <= w_idx_nxt;
            r_valid <= w_valid_nxt;
        end
    end

    assign grant_out       = r_grant;
    assign grant_idx_out   = r_idx;
    assign grant_valid_out = r_valid;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Self-checking bench for rr_arbiter8: directed vector table, hand-written
// corner sequences, and randomized stimulus against a behavioural model.
module tb_rr_arbiter8;

`ifdef RR_ARB_TIMEOUT_EN
    localparam int TB_HOLD = 4;
`else
    localparam int TB_HOLD = 16;
`endif

    logic       clk;
    logic       rst;
    logic [7:0] req_in;
    logic       done_in;
    logic [7:0] grant_out;
    logic [2:0] grant_idx_out;
    logic       grant_valid_out;
    logic       timeout_out;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state
    int m_holder;   // -1 when nobody holds the grant
    int m_ptr;
    int m_last;
    int m_held;     // cycles the current grant has been visible
    bit m_to;

    typedef struct {
        logic [7:0] req;
        logic       done;
        logic [7:0] e_grant;
        logic [2:0] e_idx;
        logic       e_valid;
        logic       e_to;
    } vec_t;

    vec_t vecs[10];

    rr_arbiter8 #(.HOLD_MAX(TB_HOLD)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_in         (req_in),
        .done_in        (done_in),
        .grant_out      (grant_out),
        .grant_idx_out  (grant_idx_out),
        .grant_valid_out(grant_valid_out),
        .timeout_out    (timeout_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string name, input logic [7:0] g, input logic [2:0] i,
                           input logic v, input logic t);
        chk({name, ".grant"}, grant_out, g);
        chk({name, ".idx"}, {5'd0, grant_idx_out}, {5'd0, i});
        chk({name, ".valid"}, {7'd0, grant_valid_out}, {7'd0, v});
        chk({name, ".timeout"}, {7'd0, timeout_out}, {7'd0, t});
    endtask

    task automatic model_reset();
        m_holder = -1;
        m_ptr    = 0;
        m_last   = 0;
        m_held   = 0;
        m_to     = 1'b0;
    endtask

    // Advance the model by one edge using the inputs currently applied.
    task automatic model_step(input logic [7:0] req, input logic done);
        bit a, b, c;
        if (m_holder < 0) begin
            m_to = 1'b0;
            if (req != 8'h00) begin
                for (int k = 0; k < 8; k++) begin
                    if (m_holder < 0 && req[(m_ptr + k) % 8]) m_holder = (m_ptr + k) % 8;
                end
                m_last = m_holder;
                m_held = 1;
            end
        end else begin
            a = !req[m_holder];
            b = done;
`ifdef RR_ARB_TIMEOUT_EN
            c = (m_held == TB_HOLD);
`else
            c = 1'b0;
`endif
            if (a || b || c) begin
                m_to     = c && !a && !b;
                m_ptr    = (m_holder + 1) % 8;
                m_holder = -1;
            end else begin
                m_to   = 1'b0;
                m_held = m_held + 1;
            end
        end
    endtask

    task automatic apply_reset();
        rst     = 1'b1;
        req_in  = 8'h00;
        done_in = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic cycle(input logic [7:0] req, input logic done);
        req_in  = req;
        done_in = done;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst     = 1'b1;
        req_in  = 8'h00;
        done_in = 1'b0;
        model_reset();

        // Directed vectors from a fresh reset.
        vecs[0] = '{8'h05, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0};
        vecs[1] = '{8'h04, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
        vecs[2] = '{8'h04, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0};
        vecs[3] = '{8'h04, 1'b1, 8'h00, 3'd2, 1'b0, 1'b0};
        vecs[4] = '{8'h00, 1'b1, 8'h00, 3'd2, 1'b0, 1'b0};
        vecs[5] = '{8'h81, 1'b0, 8'h80, 3'd7, 1'b1, 1'b0};
        vecs[6] = '{8'h81, 1'b1, 8'h00, 3'd7, 1'b0, 1'b0};
        vecs[7] = '{8'h81, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0};
        vecs[8] = '{8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0};
        vecs[9] = '{8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};

        @(posedge clk);
        #1;
        chk_all("reset", 8'h00, 3'd0, 1'b0, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycle(vecs[i].req, vecs[i].done);
            chk_all($sformatf("vec%0d", i), vecs[i].e_grant, vecs[i].e_idx,
                    vecs[i].e_valid, vecs[i].e_to);
        end

        // Rotation with all requesters active and done after every grant.
        apply_reset();
        for (int k = 0; k < 9; k++) begin
            cycle(8'hFF, 1'b0);
            chk_all($sformatf("rot_grant%0d", k), 8'h01 << (k % 8), 3'(k % 8), 1'b1, 1'b0);
            cycle(8'hFF, 1'b1);
            chk_all($sformatf("rot_idle%0d", k), 8'h00, 3'(k % 8), 1'b0, 1'b0);
        end

        // Single requester held continuously.
        apply_reset();
`ifdef RR_ARB_TIMEOUT_EN
        for (int t = 0; t < 15; t++) begin
            cycle(8'h08, 1'b0);
            if ((t % 5) < 4) chk_all($sformatf("hold%0d", t), 8'h08, 3'd3, 1'b1, 1'b0);
            else             chk_all($sformatf("hold%0d", t), 8'h00, 3'd3, 1'b0, 1'b1);
        end
`else
        for (int t = 0; t < 110; t++) begin
            cycle(8'h08, 1'b0);
            chk_all($sformatf("hold%0d", t), 8'h08, 3'd3, 1'b1, 1'b0);
        end
`endif

        // Asynchronous reset in the middle of a grant, then restart from ptr 0.
        apply_reset();
        cycle(8'h20, 1'b0);
        chk_all("pre_r5", 8'h20, 3'd5, 1'b1, 1'b0);
        cycle(8'h20, 1'b1);
        cycle(8'h10, 1'b0);
        chk_all("pre_r4", 8'h10, 3'd4, 1'b1, 1'b0);
        rst = 1'b1;
        #1;
        chk_all("async_rst", 8'h00, 3'd0, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        cycle(8'h30, 1'b0);
        chk_all("post_rst", 8'h10, 3'd4, 1'b1, 1'b0);

        // Randomized traffic checked against the model.
        apply_reset();
        for (int n = 0; n < 600; n++) begin
            logic [7:0] r;
            logic       d;
            r = req_in;
            if ($urandom_range(0, 3) == 0) r = 8'($urandom);
            d = ($urandom_range(0, 5) == 0);
            model_step(r, d);
            cycle(r, d);
            chk_all($sformatf("rnd%0d", n),
                    (m_holder >= 0) ? (8'h01 << m_holder) : 8'h00,
                    3'(m_last), (m_holder >= 0), m_to);
            chk("onehot", {7'd0, ($countones(grant_out) <= 1)}, 8'h01);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
